// File: rtl/cve2_multdiv_ctrl_if.sv
// ---------------------------------------------------------------------------
// cve2_multdiv_ctrl_if
//
// Request/response bundle between the ID/writeback side and the multiply /
// divide controller. Signal names keep the controller's point of view
// (_i = into the controller, _o = out of the controller).
//
//   req_valid_i / req_ready_o : operation offer / accept handshake
//   req_op_i                  : operation (md_op_e encoding)
//   req_signed_mode_i         : operand signedness
//   req_op_a_i / req_op_b_i   : operands
//   rsp_valid_o / rsp_ready_i : writeback handshake
//   rsp_result_o              : result (0 on timeout)
//   rsp_cycles_o              : BUSY cycles consumed, including the last one
//   rsp_err_o                 : timeout flag
//
// Modports: slave = controller side, master = ID/writeback side.
// ---------------------------------------------------------------------------
interface cve2_multdiv_ctrl_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_op_i;
  logic [1:0]  req_signed_mode_i;
  logic [31:0] req_op_a_i;
  logic [31:0] req_op_b_i;

  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_result_o;
  logic [5:0]  rsp_cycles_o;
  logic        rsp_err_o;

  modport slave (
    input  req_valid_i, req_op_i, req_signed_mode_i, req_op_a_i, req_op_b_i,
    input  rsp_ready_i,
    output req_ready_o,
    output rsp_valid_o, rsp_result_o, rsp_cycles_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_op_i, req_signed_mode_i, req_op_a_i, req_op_b_i,
    output rsp_ready_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_result_o, rsp_cycles_o, rsp_err_o
  );
endinterface

// File: rtl/cve2_multdiv_ctrl.sv
// ---------------------------------------------------------------------------
// cve2_multdiv_ctrl
//
// Sequences one multiply/divide operation at a time through an external
// multdiv unit: accepts a request in IDLE, latches its fields, drives the
// unit while BUSY, counts BUSY cycles, and presents the result (or a
// timeout error after MaxCycles BUSY cycles) in RESP until it is consumed.
//
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   bus (slave)          : request / response handshake bundle
//   mult_en_o, div_en_o  : dynamic enables, only in BUSY
//   mult_sel_o, div_sel_o: static selects from the latched operation
//   operator_o, signed_mode_o, op_a_o, op_b_o : latched operation fields
//   multdiv_ready_id_o   : result-consume strobe, only in BUSY
//   valid_i, result_i    : result from the multdiv unit
//   kill_i               : abort any in-flight operation
// ---------------------------------------------------------------------------
module cve2_multdiv_ctrl #(
  parameter int unsigned MaxCycles = 40  // timeout in BUSY cycles, 1..63
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  cve2_multdiv_ctrl_if.slave        bus,
  output logic                      mult_en_o,
  output logic                      div_en_o,
  output logic                      mult_sel_o,
  output logic                      div_sel_o,
  output logic [1:0]                operator_o,
  output logic [1:0]                signed_mode_o,
  output logic [31:0]               op_a_o,
  output logic [31:0]               op_b_o,
  output logic                      multdiv_ready_id_o,
  input  logic                      valid_i,
  input  logic [31:0]               result_i,
  input  logic                      kill_i
);

  // Same encoding as cve2_pkg::md_op_e.
  typedef enum logic [1:0] {
    MD_OP_MULL = 2'b00,
    MD_OP_MULH = 2'b01,
    MD_OP_DIV  = 2'b10,
    MD_OP_REM  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_RESP = 2'b10
  } state_e;

  localparam logic [5:0] MaxCyclesW = 6'(MaxCycles);

  state_e      r_state;
  state_e      w_state_d;
  logic        w_accept;
  logic        w_done;
  logic        w_timeout;
  logic [5:0]  w_cnt_inc;

  md_op_e      r_op;
  logic [1:0]  r_signed_mode;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic        r_mult_sel;
  logic        r_div_sel;
  logic [5:0]  r_cnt;
  logic [31:0] r_rsp_result;
  logic [5:0]  r_rsp_cycles;
  logic        r_rsp_err;

  // Counter value including the current BUSY cycle, saturating at 63.
  assign w_cnt_inc = (r_cnt == 6'd63) ? r_cnt : r_cnt + 6'd1;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    w_state_d = r_state;
    w_accept  = 1'b0;
    w_done    = 1'b0;
    w_timeout = 1'b0;
    if (kill_i) begin
      // Abort wins over accept, completion, timeout and consume.
      w_state_d = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.req_valid_i) begin
            w_accept  = 1'b1;
            w_state_d = S_BUSY;
          end
        end
        S_BUSY: begin
          if (valid_i) begin
            w_done    = 1'b1;
            w_state_d = S_RESP;
          end else if (w_cnt_inc == MaxCyclesW) begin
            w_timeout = 1'b1;
            w_state_d = S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready_i) begin
            w_state_d = S_IDLE;
          end
        end
        default: w_state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: the datapath registers are reset as well, because their values are
  // visible on outputs that must read as zero while rst_ni is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op          <= MD_OP_MULL;
      r_signed_mode <= 2'b00;
      r_op_a        <= 32'd0;
      r_op_b        <= 32'd0;
      r_mult_sel    <= 1'b0;
      r_div_sel     <= 1'b0;
      r_cnt         <= 6'd0;
      r_rsp_result  <= 32'd0;
      r_rsp_cycles  <= 6'd0;
      r_rsp_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op          <= md_op_e'(bus.req_op_i);
        r_signed_mode <= bus.req_signed_mode_i;
        r_op_a        <= bus.req_op_a_i;
        r_op_b        <= bus.req_op_b_i;
        // Selects are registered alongside the op so they stay low out of
        // reset, where the cleared op field would otherwise decode as MULL.
        r_mult_sel    <= (md_op_e'(bus.req_op_i) == MD_OP_MULL) ||
                         (md_op_e'(bus.req_op_i) == MD_OP_MULH);
        r_div_sel     <= (md_op_e'(bus.req_op_i) == MD_OP_DIV) ||
                         (md_op_e'(bus.req_op_i) == MD_OP_REM);
        r_cnt         <= 6'd0;
      end else if (r_state == S_BUSY) begin
        r_cnt <= w_cnt_inc;
      end

      if (w_done) begin
        r_rsp_result <= result_i;
        r_rsp_cycles <= w_cnt_inc;
        r_rsp_err    <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_result <= 32'd0;
        r_rsp_cycles <= MaxCyclesW;
        r_rsp_err    <= 1'b1;
      end
    end
  end

  assign bus.req_ready_o  = (r_state == S_IDLE);
  assign bus.rsp_valid_o  = (r_state == S_RESP);
  assign bus.rsp_result_o = r_rsp_result;
  assign bus.rsp_cycles_o = r_rsp_cycles;
  assign bus.rsp_err_o    = r_rsp_err;

  assign mult_sel_o         = r_mult_sel;
  assign div_sel_o          = r_div_sel;
  assign mult_en_o          = r_mult_sel && (r_state == S_BUSY);
  assign div_en_o           = r_div_sel  && (r_state == S_BUSY);
  assign multdiv_ready_id_o = (r_state == S_BUSY);

  assign operator_o    = r_op;
  assign signed_mode_o = r_signed_mode;
  assign op_a_o        = r_op_a;
  assign op_b_o        = r_op_b;

endmodule

// File: tb/tb_cve2_multdiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cve2_multdiv_ctrl
//
// Drives directed and randomized operations into cve2_multdiv_ctrl, plays the
// multdiv unit with a chosen latency, and compares outputs against an
// arithmetic reference: result from the operation itself, cycles/err from
// min(latency, MaxCycles). Inputs change and outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_cve2_multdiv_ctrl;

  localparam int unsigned MAXC = 40;
  localparam logic [1:0]  MULL = 2'd0;
  localparam logic [1:0]  MULH = 2'd1;
  localparam logic [1:0]  DIV  = 2'd2;
  localparam logic [1:0]  REM  = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mult_en, div_en, mult_sel, div_sel, md_ready;
  logic [1:0]  oper, smode;
  logic [31:0] op_a, op_b;
  logic        valid;
  logic [31:0] result;
  logic        kill;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cve2_multdiv_ctrl_if u_if ();

  cve2_multdiv_ctrl #(.MaxCycles(MAXC)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .bus                (u_if.slave),
    .mult_en_o          (mult_en),
    .div_en_o           (div_en),
    .mult_sel_o         (mult_sel),
    .div_sel_o          (div_sel),
    .operator_o         (oper),
    .signed_mode_o      (smode),
    .op_a_o             (op_a),
    .op_b_o             (op_b),
    .multdiv_ready_id_o (md_ready),
    .valid_i            (valid),
    .result_i           (result),
    .kill_i             (kill)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Observed control outputs packed as
  // {mult_en, div_en, mult_sel, div_sel, multdiv_ready, req_ready, rsp_valid}.
  function automatic logic [6:0] flags();
    return {mult_en, div_en, mult_sel, div_sel, md_ready,
            u_if.req_ready_o, u_if.rsp_valid_o};
  endfunction

  // What the multdiv unit would compute (unsigned interpretation).
  function automatic logic [31:0] md_model(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      MULL:    return p[31:0];
      MULH:    return p[63:32];
      DIV:     return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic is_mul(input logic [1:0] op);
    return (op == MULL) || (op == MULH);
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_flags"}, 32'(flags()), 32'(7'b0000010));
    check({tag, "_op_a"}, op_a, 32'd0);
    check({tag, "_op_b"}, op_b, 32'd0);
    check({tag, "_oper_mode"}, {28'd0, oper, smode}, 32'd0);
    check({tag, "_rsp_result"}, u_if.rsp_result_o, 32'd0);
    check({tag, "_rsp_cyc_err"}, {25'd0, u_if.rsp_cycles_o, u_if.rsp_err_o}, 32'd0);
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [1:0] sm,
                           input logic [31:0] a, input logic [31:0] b);
    u_if.req_valid_i       = 1'b1;
    u_if.req_op_i          = op;
    u_if.req_signed_mode_i = sm;
    u_if.req_op_a_i        = a;
    u_if.req_op_b_i        = b;
  endtask

  task automatic scramble_req();
    u_if.req_valid_i       = 1'b0;
    u_if.req_op_i          = 2'($urandom);
    u_if.req_signed_mode_i = 2'($urandom);
    u_if.req_op_a_i        = $urandom;
    u_if.req_op_b_i        = $urandom;
  endtask

  // Full transaction. Entered and left just after a falling edge.
  // lat = BUSY cycle on which the model asserts valid_i (> MAXC: never).
  task automatic do_op(input logic [1:0] op, input logic [1:0] sm, input logic [31:0] a,
                       input logic [31:0] b, input int lat, input int rsp_wait);
    logic        m, d, exp_err;
    logic [31:0] exp_res;
    logic [5:0]  exp_cyc;
    int          n_busy, en_cnt;
    m = is_mul(op);
    d = !m;
    if (lat <= int'(MAXC)) begin
      n_busy = lat; exp_res = md_model(op, a, b); exp_cyc = 6'(lat); exp_err = 1'b0;
    end else begin
      n_busy = MAXC; exp_res = 32'd0; exp_cyc = 6'(MAXC); exp_err = 1'b1;
    end
    check("idle_req_ready", 32'(u_if.req_ready_o), 32'd1);
    drive_req(op, sm, a, b);
    en_cnt = 0;
    for (int k = 1; k <= n_busy; k++) begin
      @(negedge clk);
      if (k == 1) scramble_req();
      check("busy_flags", 32'(flags()), 32'({m, d, m, d, 1'b1, 1'b0, 1'b0}));
      check("busy_op_a", op_a, a);
      check("busy_op_b", op_b, b);
      check("busy_oper_mode", {28'd0, oper, smode}, {28'd0, op, sm});
      if (mult_en || div_en) en_cnt++;
      valid  = (k == lat);
      result = (k == lat) ? md_model(op, a, b) : $urandom;
    end
    @(negedge clk);
    valid = 1'b0;
    check("enable_cycles", en_cnt, n_busy);
    check("resp_flags", 32'(flags()), 32'({1'b0, 1'b0, m, d, 1'b0, 1'b0, 1'b1}));
    check("resp_result", u_if.rsp_result_o, exp_res);
    check("resp_cycles", 32'(u_if.rsp_cycles_o), 32'(exp_cyc));
    check("resp_err", 32'(u_if.rsp_err_o), 32'(exp_err));
    for (int w = 0; w < rsp_wait; w++) begin
      valid  = 1'($urandom);
      result = $urandom;
      @(negedge clk);
      check("hold_flags", 32'(flags()), 32'({1'b0, 1'b0, m, d, 1'b0, 1'b0, 1'b1}));
      check("hold_result", u_if.rsp_result_o, exp_res);
      check("hold_cyc_err", {25'd0, u_if.rsp_cycles_o, u_if.rsp_err_o},
            {25'd0, exp_cyc, exp_err});
    end
    valid = 1'b0;
    u_if.rsp_ready_i = 1'b1;
    @(negedge clk);
    u_if.rsp_ready_i = 1'b0;
    check("done_flags", 32'(flags()), 32'({1'b0, 1'b0, m, d, 1'b0, 1'b1, 1'b0}));
  endtask

  // Abort on BUSY cycle k_at with valid_i asserted in the same cycle.
  task automatic kill_busy(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int k_at);
    logic m, d;
    m = is_mul(op);
    d = !m;
    drive_req(op, 2'b00, a, b);
    for (int k = 1; k <= k_at; k++) begin
      @(negedge clk);
      if (k == 1) scramble_req();
      valid  = (k == k_at);
      kill   = (k == k_at);
      result = $urandom;
    end
    @(negedge clk);
    valid = 1'b0;
    kill  = 1'b0;
    check("kill_busy_flags", 32'(flags()), 32'({1'b0, 1'b0, m, d, 1'b0, 1'b1, 1'b0}));
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      check("kill_busy_no_rsp", 32'({u_if.rsp_valid_o, u_if.req_ready_o}), 32'd1);
    end
  endtask

  // Abort while a response is pending and not yet consumed.
  task automatic kill_resp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic m, d;
    m = is_mul(op);
    d = !m;
    drive_req(op, 2'b00, a, b);
    @(negedge clk);
    scramble_req();
    valid  = 1'b1;
    result = md_model(op, a, b);
    @(negedge clk);
    valid = 1'b0;
    check("kill_resp_pending", 32'(u_if.rsp_valid_o), 32'd1);
    kill = 1'b1;
    u_if.rsp_ready_i = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    u_if.rsp_ready_i = 1'b0;
    check("kill_resp_flags", 32'(flags()), 32'({1'b0, 1'b0, m, d, 1'b0, 1'b1, 1'b0}));
  endtask

  // Abort in IDLE while a request is offered: the request must not be taken.
  task automatic kill_idle(input logic [31:0] prev_a);
    drive_req(2'($urandom), 2'($urandom), ~prev_a, $urandom);
    kill = 1'b1;
    @(negedge clk);
    scramble_req();
    kill = 1'b0;
    check("kill_idle_ready", 32'({u_if.req_ready_o, md_ready}), 32'd2);
    check("kill_idle_op_a", op_a, prev_a);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;
    int          r_lat;

    u_if.req_valid_i = 1'b0; u_if.req_op_i = 2'd0; u_if.req_signed_mode_i = 2'd0;
    u_if.req_op_a_i = 32'd0; u_if.req_op_b_i = 32'd0; u_if.rsp_ready_i = 1'b0;
    valid = 1'b0; result = 32'd0; kill = 1'b0;

    #12;
    check_reset("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_flags", 32'(flags()), 32'(7'b0000010));

    // Directed cases.
    do_op(MULL, 2'b00, 32'd3, 32'd5, 4, 0);
    do_op(DIV, 2'b11, 32'd100, 32'd7, 37, 1);
    do_op(REM, 2'b01, 32'd100, 32'd7, 1000, 0);       // never valid: timeout
    do_op(MULH, 2'b10, 32'hDEAD_BEEF, 32'h1234_5678, 3, 5);
    do_op(MULL, 2'b00, 32'd9, 32'd9, int'(MAXC), 0);    // valid on the timeout cycle
    do_op(DIV, 2'b00, 32'd9, 32'd2, int'(MAXC) + 1, 0); // one cycle too late
    do_op(REM, 2'b00, 32'd17, 32'd5, 1, 2);             // minimum latency

    kill_busy(MULL, 32'd11, 32'd12, 3);
    kill_busy(DIV, 32'd50, 32'd3, 1);
    kill_resp(REM, 32'd23, 32'd4);
    kill_idle(32'd23);

    // Asynchronous reset on BUSY cycle 2.
    drive_req(MULH, 2'b11, 32'h8000_0001, 32'h7FFF_FFFF);
    @(negedge clk);
    scramble_req();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("rst_busy");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(DIV, 2'b01, 32'd1000, 32'd10, 6, 0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      r_op  = 2'($urandom);
      r_a   = $urandom;
      r_b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      r_lat = $urandom_range(1, int'(MAXC) + 5);
      if (i % 7 == 6)
        kill_busy(r_op, r_a, r_b, $urandom_range(1, int'(MAXC) - 1));
      else
        do_op(r_op, 2'($urandom), r_a, r_b, r_lat, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
